// File: rtl/avg_filter_scheduler.sv
// Time-shared 2-sample averager: per-channel holding/history registers,
// round-robin issue into a 2-stage sum/shift pipeline.
`timescale 1ns/1ps
module avg_filter_scheduler #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CHW = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        i_ce,
  input  logic [NCH*DW-1:0]     data_in,
  input  logic                  i_clr_ovf,
  output logic signed [DW-1:0]  data_out,
  output logic [CHW-1:0]        o_chan,
  output logic                  o_ce,
  output logic [NCH-1:0]        o_ovf
);

  logic signed [DW-1:0] samp   [NCH];
  logic signed [DW-1:0] hold_d [NCH];
  logic signed [DW-1:0] hist   [NCH];
  logic [NCH-1:0]       hold_v;
  logic [NCH-1:0]       gnt_oh;
  logic [NCH-1:0]       accept;
  logic [NCH-1:0]       ovf_set;
  logic                 gnt_v;
  logic [CHW-1:0]       gnt;
  logic [CHW-1:0]       idx;
  logic [CHW-1:0]       ptr;
  logic [CHW-1:0]       ptr_nx;
  logic signed [DW:0]   sum_nx;
  logic signed [DW:0]   sum_ff;
  logic [CHW-1:0]       chan_ff;
  logic                 sum_v;

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      samp[c] = data_in[c*DW +: DW];
    end
  end

  // Round-robin scan over registered valids only, starting at ptr.
  always_comb begin
    gnt_v  = 1'b0;
    gnt    = '0;
    idx    = '0;
    gnt_oh = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = CHW'((32'(ptr) + i) % NCH);
      if (!gnt_v && hold_v[idx]) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
    if (gnt_v) gnt_oh[gnt] = 1'b1;
    ptr_nx = CHW'((32'(gnt) + 1) % NCH);
    sum_nx = {hold_d[gnt][DW-1], hold_d[gnt]} + {hist[gnt][DW-1], hist[gnt]};
  end

  // A slot being granted this cycle may be refilled in the same cycle.
  assign accept  = i_ce & (~hold_v | gnt_oh);
  assign ovf_set = i_ce & hold_v & ~gnt_oh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_v   <= '0;
      ptr      <= '0;
      sum_ff   <= '0;
      chan_ff  <= '0;
      sum_v    <= 1'b0;
      data_out <= '0;
      o_chan   <= '0;
      o_ce     <= 1'b0;
      o_ovf    <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        hold_d[c] <= '0;
        hist[c]   <= '0;
      end
    end else begin
      hold_v <= (hold_v & ~gnt_oh) | accept;
      for (int unsigned c = 0; c < NCH; c++) begin
        if (accept[c]) hold_d[c] <= samp[c];
      end
      o_ovf <= (i_clr_ovf ? '0 : o_ovf) | ovf_set;

      sum_v <= gnt_v;
      if (gnt_v) begin
        sum_ff    <= sum_nx;
        chan_ff   <= gnt;
        hist[gnt] <= hold_d[gnt];
        ptr       <= ptr_nx;
      end

      o_ce <= sum_v;
      if (sum_v) begin
        data_out <= sum_ff[DW:1];
        o_chan   <= chan_ff;
      end
    end
  end

endmodule

// File: tb/tb_avg_filter_scheduler.sv
// Scoreboard bench for avg_filter_scheduler (NCH=4, DW=8).
`timescale 1ns/1ps
module tb_avg_filter_scheduler;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [3:0]        i_ce = '0;
  logic [31:0]       data_in = '0;
  logic              i_clr_ovf = 1'b0;
  logic signed [7:0] data_out;
  logic [1:0]        o_chan;
  logic              o_ce;
  logic [3:0]        o_ovf;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]        ch;
    logic signed [7:0] d;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  avg_filter_scheduler #(.NCH(4), .DW(8), .CHW(2)) dut (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .data_in(data_in),
    .i_clr_ovf(i_clr_ovf), .data_out(data_out), .o_chan(o_chan),
    .o_ce(o_ce), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (reset_n && o_ce) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_oce: got chan=%0d data=%0d, required no output", o_chan, data_out);
      end else begin
        mon_e = sb.pop_front();
        if (o_chan !== mon_e.ch || data_out !== mon_e.d) begin
          errors++;
          $display("FAIL sb_out: got chan=%0d data=%0d, required chan=%0d data=%0d",
                   o_chan, data_out, mon_e.ch, mon_e.d);
        end
      end
    end
  end

  function automatic void push(input logic [1:0] ch, input logic signed [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    sb.push_back(e);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] m, input logic signed [7:0] a, b, c, d);
    i_ce    = m;
    data_in = {d, c, b, a};
    cyc();
    i_ce = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outputs outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    i_ce      = '0;
    i_clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (data_out !== 8'sd0) begin errors++; $display("FAIL rst_data: got %0d required 0", data_out); end
    checks++; if (o_chan !== 2'd0) begin errors++; $display("FAIL rst_chan: got %0d required 0", o_chan); end
    checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL rst_oce: got %0b required 0", o_ce); end
    checks++; if (o_ovf !== 4'b0000) begin errors++; $display("FAIL rst_ovf: got %b required 0000", o_ovf); end
  endtask

  task automatic test_latency();
    do_reset();
    push(2'd0, 8'sd50);
    strobe(4'b0001, 100, 0, 0, 0);
    cyc();
    @(negedge clk);
    checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL lat_early: got o_ce=%0b required 0 at T+2", o_ce); end
    cyc();
    @(negedge clk);
    checks++; if (o_ce !== 1'b1) begin errors++; $display("FAIL lat_t3: got o_ce=%0b required 1 at T+3", o_ce); end
    drain();
    push(2'd0, 8'sd60);
    strobe(4'b0001, 20, 0, 0, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(2'd0, 5); push(2'd1, 10); push(2'd2, 15); push(2'd3, 20);
    strobe(4'b1111, 10, 20, 30, 40);
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_ce !== 1'b1 || o_chan !== 2'(i)) begin
        errors++;
        $display("FAIL b2b_slot%0d: got o_ce=%0b chan=%0d, required o_ce=1 chan=%0d", i, o_ce, o_chan, i);
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    push(2'd1, 5); push(2'd3, 10); push(2'd1, 20); push(2'd3, 30);
    strobe(4'b1010, 0, 10, 0, 20);
    cyc();
    strobe(4'b1010, 0, 30, 0, 40);
    drain();
    checks++; if (o_ovf !== 4'b0000) begin errors++; $display("FAIL rr_ovf: got %b required 0000", o_ovf); end
  endtask

  task automatic test_overflow();
    do_reset();
    push(2'd0, 5); push(2'd1, 10); push(2'd2, 15);
    strobe(4'b0111, 10, 20, 30, 0);
    strobe(4'b0100, 0, 0, 99, 0);
    drain();
    checks++; if (o_ovf !== 4'b0100) begin errors++; $display("FAIL ovf_set: got %b required 0100", o_ovf); end
    // ptr is now 3: ch0 granted first, ch1 overflows while clear is asserted.
    push(2'd0, 30); push(2'd1, 40);
    strobe(4'b0011, 50, 60, 0, 0);
    i_clr_ovf = 1'b1;
    strobe(4'b0010, 0, 77, 0, 0);
    i_clr_ovf = 1'b0;
    drain();
    checks++; if (o_ovf !== 4'b0010) begin errors++; $display("FAIL ovf_clr_race: got %b required 0010", o_ovf); end
    i_clr_ovf = 1'b1;
    cyc();
    i_clr_ovf = 1'b0;
    @(negedge clk);
    checks++; if (o_ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b required 0000", o_ovf); end
    cyc();
  endtask

  task automatic test_extremes();
    do_reset();
    push(2'd0, 63);   strobe(4'b0001, 127, 0, 0, 0);  drain();
    push(2'd0, 127);  strobe(4'b0001, 127, 0, 0, 0);  drain();
    push(2'd0, -1);   strobe(4'b0001, -128, 0, 0, 0); drain();
    push(2'd0, -128); strobe(4'b0001, -128, 0, 0, 0); drain();
    push(2'd0, -64);  strobe(4'b0001, 0, 0, 0, 0);    drain();
    push(2'd0, -2);   strobe(4'b0001, -3, 0, 0, 0);   drain();
    push(2'd0, -2);   strobe(4'b0001, -1, 0, 0, 0);   drain();
    push(2'd0, -1);   strobe(4'b0001, 0, 0, 0, 0);    drain();
  endtask

  task automatic test_async_reset();
    int n = 0;
    strobe(4'b0111, 1, 2, 3, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL arst_oce: got %0b required 0", o_ce); end
    checks++; if (data_out !== 8'sd0) begin errors++; $display("FAIL arst_data: got %0d required 0", data_out); end
    checks++; if (o_chan !== 2'd0) begin errors++; $display("FAIL arst_chan: got %0d required 0", o_chan); end
    checks++; if (o_ovf !== 4'b0000) begin errors++; $display("FAIL arst_ovf: got %b required 0000", o_ovf); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (o_ce) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL arst_stale: got %0d o_ce pulses, required 0", n); end
    cyc();
    push(2'd0, 20);
    strobe(4'b0001, 40, 0, 0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_round_robin();
    test_overflow();
    test_extremes();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avg_filter_scheduler.md
Name: avg_filter_scheduler

Overview:
- Time-shares one 2-sample averaging datapath (y = (x[n] + x[n-1]) >>> 1) across NCH independent sample channels.
- Each channel has a 1-deep holding register and a per-channel history register.
- A round-robin arbiter issues at most one channel per cycle into a 2-stage sum/shift pipeline.
- Sits between multi-channel sample sources (ADC front-ends, decimators) and downstream per-channel consumers, which demultiplex on o_chan.

Parameters:
- NCH, 4, number of channels (2..16).
- DW, 8, signed sample width.
- CHW, 2, channel index width, must equal clog2(NCH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_ce  input  NCH  per-channel sample strobe; bit c qualifies data_in slice c.
- data_in  input  NCH*DW  packed signed samples; channel c at bits [c*DW +: DW].
- i_clr_ovf  input  1  clears all o_ovf bits.
- data_out  output  DW  signed averaged sample (registered).
- o_chan  output  CHW  channel index of data_out (registered).
- o_ce  output  1  one-cycle strobe, data_out/o_chan valid.
- o_ovf  output  NCH  sticky per-channel overflow flags (registered).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - data_out=0, o_chan=0, o_ce=0, o_ovf=0.
  - All holding-valid bits 0; all history registers 0; round-robin pointer 0; pipeline valids 0.
  - Reset asserted mid-operation discards all pending and in-flight samples; no o_ce for them after release.
- Capture:
  - i_ce[c] with holding[c] empty, or holding[c] granted in the same cycle: holding[c] <= sample, valid set.
  - i_ce[c] with holding[c] full and not granted this cycle: new sample dropped, holding[c] unchanged, o_ovf[c] <= 1.
- Arbitration:
  - Grant = first valid holding channel scanning ptr, ptr+1, ... modulo NCH.
  - Arbitration is driven from registered valid bits only; a sample is never granted in its own i_ce cycle.
  - On grant g: ptr <= (g+1) mod NCH; holding[g] valid cleared unless refilled the same cycle.
  - No grant: ptr holds.
- Stage 1 (grant cycle edge):
  - sum_ff <= sext(holding[g]) + sext(history[g]), DW+1 bits signed, no overflow possible.
  - chan_ff <= g; sum_v <= 1.
  - history[g] <= holding[g].
- Stage 2:
  - If sum_v: data_out <= sum_ff[DW:1] (arithmetic shift, rounds toward -inf), o_chan <= chan_ff, o_ce <= 1.
  - Otherwise o_ce <= 0; data_out and o_chan hold.
- Latency:
  - Uncontended sample with i_ce in cycle T gives o_ce high in cycle T+3.
  - Each cycle of arbitration wait adds one cycle.
- Throughput and ordering:
  - One output per cycle aggregate.
  - Per-channel output order equals input order.
  - A channel strobing at most once per NCH cycles never overflows, even with all channels saturated.
- History: first sample after reset averages with 0.
- Overflow clear: i_clr_ovf clears all o_ovf bits; a new overflow event in the same cycle wins (bit set).

Test Plan:
- Reset; ch0 i_ce data 100 at cycle T -> o_ce=1 at T+3, data_out=50, o_chan=0; then ch0 data 20 -> data_out=60.
- All four i_ce in one cycle, data 10,20,30,40 (fresh history) -> four consecutive o_ce cycles, o_chan 0,1,2,3, data_out 5,10,15,20.
- Round robin: ch1 and ch3 strobe every 2 cycles, ptr starts 0 -> grants alternate 1,3,1,3; no o_ovf bits set.
- Overflow: ch0, ch1, ch2 all strobe at T; ch2 strobes again at T+1 (ch2 not yet granted) -> second ch2 sample dropped, o_ovf[2]=1, ch2 output uses first sample; i_clr_ovf pulse -> o_ovf=0.
- Extremes on ch0:
  - 127 then 127 -> 127.
  - -128 then -128 -> -128.
  - 0 then -3 -> -2.
  - -1 then 0 -> -1.
- Async reset: drop reset_n between edges while three channels are pending -> outputs 0 immediately; after release no o_ce; next ch0 sample 40 -> 20.
